// File: rtl/user_io_mux_irq_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | user_io_mux_irq_if : Wishbone slave bundle for user_io_mux_irq     |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
interface user_io_mux_irq_if;
    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_dat_i;
    logic [31:0] wbs_adr_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
        output wbs_ack_o, wbs_dat_o
    );
endinterface
`default_nettype wire

// File: rtl/user_io_mux_irq.sv
`default_nettype none
// +------------------------------------------------------------------+
// | user_io_mux_irq : pad mux + GPIO/peripheral interrupt controller  |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module user_io_mux_irq #(
    parameter int          NUM_PINS    = 12,
    parameter int          NUM_SRC     = 4,
    parameter int          SYNC_STAGES = 2,
    parameter logic [31:0] ADDR_BASE   = 32'h3000_1000
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_n_i,
    user_io_mux_irq_if.slave    wbs,
    input  logic [NUM_PINS-1:0] io_in,
    output logic [NUM_PINS-1:0] io_out,
    output logic [NUM_PINS-1:0] io_oeb,
    input  logic [NUM_PINS-1:0] periph_out,
    input  logic [NUM_PINS-1:0] periph_oeb,
    output logic [NUM_PINS-1:0] periph_in,
    input  logic [NUM_SRC-1:0]  src_irq_i,
    output logic [2:0]          irq
);
    localparam logic [5:0]  c_OFF_FUNC     = 6'h00;
    localparam logic [5:0]  c_OFF_GPIO_OUT = 6'h01;
    localparam logic [5:0]  c_OFF_GPIO_IN  = 6'h02;
    localparam logic [5:0]  c_OFF_PEND     = 6'h03;
    localparam logic [5:0]  c_OFF_MASK     = 6'h04;
    localparam logic [5:0]  c_OFF_ID       = 6'h05;
    localparam logic [31:0] c_ID = 32'h1010_0000 | (32'(NUM_SRC) << 8) | 32'(NUM_PINS);

    logic [2*NUM_PINS-1:0] r_func;
    logic [NUM_PINS-1:0]   r_gpio_out;
    logic [NUM_PINS-1:0]   r_mask_pin;
    logic [NUM_SRC-1:0]    r_mask_src;
    logic [NUM_PINS-1:0]   r_pend_pin;
    logic [NUM_SRC-1:0]    r_pend_src;
    logic [NUM_PINS-1:0]   r_pin_sync [SYNC_STAGES];
    logic [NUM_SRC-1:0]    r_src_sync [SYNC_STAGES];
    logic [NUM_PINS-1:0]   r_pin_prev;
    logic                  r_ack;
    logic [31:0]           r_dat;
    logic [1:0]            r_irq;

    logic [31:0]           w_be;
    logic                  w_hit;
    logic                  w_acc;
    logic                  w_wr;
    logic [5:0]            w_off;
    logic [31:0]           w_rdata;
    logic [NUM_PINS-1:0]   w_pin_sync;
    logic [NUM_SRC-1:0]    w_src_sync;
    logic [NUM_PINS-1:0]   w_pin_rise;
    logic [NUM_PINS-1:0]   w_clr_pin;
    logic [NUM_SRC-1:0]    w_clr_src;
    logic                  w_unused_adr;

    assign w_be  = {{8{wbs.wbs_sel_i[3]}}, {8{wbs.wbs_sel_i[2]}},
                    {8{wbs.wbs_sel_i[1]}}, {8{wbs.wbs_sel_i[0]}}};
    assign w_hit = wbs.wbs_cyc_i & wbs.wbs_stb_i & (wbs.wbs_adr_i[31:8] == ADDR_BASE[31:8]);
    assign w_acc = w_hit & ~r_ack;
    assign w_wr  = w_acc & wbs.wbs_we_i;
    assign w_off = wbs.wbs_adr_i[7:2];
    assign w_unused_adr = &{1'b0, wbs.wbs_adr_i[1:0]};

    assign w_pin_sync = r_pin_sync[SYNC_STAGES-1];
    assign w_src_sync = r_src_sync[SYNC_STAGES-1];
    assign w_pin_rise = w_pin_sync & ~r_pin_prev;
    assign periph_in  = w_pin_sync;

    assign w_clr_pin = (w_wr && w_off == c_OFF_PEND) ?
                       (wbs.wbs_dat_i[16 +: NUM_PINS] & w_be[16 +: NUM_PINS]) : '0;
    assign w_clr_src = (w_wr && w_off == c_OFF_PEND) ?
                       (wbs.wbs_dat_i[NUM_SRC-1:0] & w_be[NUM_SRC-1:0]) : '0;

    always_comb begin
        w_rdata = '0;
        case (w_off)
            c_OFF_FUNC:     w_rdata = 32'(r_func);
            c_OFF_GPIO_OUT: w_rdata = 32'(r_gpio_out);
            c_OFF_GPIO_IN:  w_rdata = 32'(w_pin_sync);
            c_OFF_PEND:     w_rdata = (32'(r_pend_pin) << 16) | 32'(r_pend_src);
            c_OFF_MASK:     w_rdata = (32'(r_mask_pin) << 16) | 32'(r_mask_src);
            c_OFF_ID:       w_rdata = c_ID;
            default:        w_rdata = '0;
        endcase
    end

    // Synchronisers plus the previous-value flop used for rising-edge detect.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_pin_sync[i] <= '0;
                r_src_sync[i] <= '0;
            end
            r_pin_prev <= '0;
        end else begin
            r_pin_sync[0] <= io_in;
            r_src_sync[0] <= src_irq_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_pin_sync[i] <= r_pin_sync[i-1];
                r_src_sync[i] <= r_src_sync[i-1];
            end
            r_pin_prev <= w_pin_sync;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            r_ack      <= 1'b0;
            r_dat      <= '0;
            r_func     <= '0;
            r_gpio_out <= '0;
            r_mask_pin <= '0;
            r_mask_src <= '0;
            r_pend_pin <= '0;
            r_pend_src <= '0;
            r_irq      <= '0;
        end else begin
            r_ack <= w_acc;
            r_dat <= w_acc ? w_rdata : '0;
            if (w_wr && w_off == c_OFF_FUNC)
                r_func <= (r_func & ~w_be[2*NUM_PINS-1:0])
                        | (wbs.wbs_dat_i[2*NUM_PINS-1:0] & w_be[2*NUM_PINS-1:0]);
            if (w_wr && w_off == c_OFF_GPIO_OUT)
                r_gpio_out <= (r_gpio_out & ~w_be[NUM_PINS-1:0])
                            | (wbs.wbs_dat_i[NUM_PINS-1:0] & w_be[NUM_PINS-1:0]);
            if (w_wr && w_off == c_OFF_MASK) begin
                r_mask_src <= (r_mask_src & ~w_be[NUM_SRC-1:0])
                            | (wbs.wbs_dat_i[NUM_SRC-1:0] & w_be[NUM_SRC-1:0]);
                r_mask_pin <= (r_mask_pin & ~w_be[16 +: NUM_PINS])
                            | (wbs.wbs_dat_i[16 +: NUM_PINS] & w_be[16 +: NUM_PINS]);
            end
            // A new event in the same clock as a clear keeps the bit set.
            r_pend_src <= (r_pend_src & ~w_clr_src) | w_src_sync;
            r_pend_pin <= (r_pend_pin & ~w_clr_pin) | w_pin_rise;
            r_irq[0]   <= |(r_pend_src & r_mask_src);
            r_irq[1]   <= |(r_pend_pin & r_mask_pin);
        end
    end

    assign wbs.wbs_ack_o = r_ack;
    assign wbs.wbs_dat_o = r_dat;
    assign irq           = {1'b0, r_irq};

    generate
        for (genvar k = 0; k < NUM_PINS; k++) begin : g_pin
            always_comb begin
                io_out[k] = 1'b0;
                io_oeb[k] = 1'b1;
                case (r_func[2*k +: 2])
                    2'd1: begin
                        io_out[k] = r_gpio_out[k];
                        io_oeb[k] = 1'b0;
                    end
                    2'd2: begin
                        io_out[k] = periph_out[k];
                        io_oeb[k] = periph_oeb[k];
                    end
                    default: begin
                        io_out[k] = 1'b0;
                        io_oeb[k] = 1'b1;
                    end
                endcase
            end
        end
    endgenerate
endmodule
`default_nettype wire

// File: tb/tb_user_io_mux_irq.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_user_io_mux_irq : randomized self-checking bench               |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module tb_user_io_mux_irq;
    localparam int          NP     = 12;
    localparam int          NS     = 4;
    localparam logic [31:0] BASE   = 32'h3000_1000;
    localparam logic [31:0] ID_EXP = 32'h1010_040C;
    localparam logic [31:0] V_FUNC = 32'h00FF_FFFF;
    localparam logic [31:0] V_PIN  = 32'h0000_0FFF;
    localparam logic [31:0] V_PEND = 32'h0FFF_000F;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    user_io_mux_irq_if wb ();
    logic [NP-1:0] io_in = '0, periph_out = '0, periph_oeb = '0;
    logic [NP-1:0] io_out, io_oeb, periph_in;
    logic [NS-1:0] src_irq = '0;
    logic [2:0]    irq;

    user_io_mux_irq #(.NUM_PINS(NP), .NUM_SRC(NS), .SYNC_STAGES(2), .ADDR_BASE(BASE)) dut (
        .wb_clk_i   (clk),
        .wb_rst_n_i (rst_n),
        .wbs        (wb),
        .io_in      (io_in),
        .io_out     (io_out),
        .io_oeb     (io_oeb),
        .periph_out (periph_out),
        .periph_oeb (periph_oeb),
        .periph_in  (periph_in),
        .src_irq_i  (src_irq),
        .irq        (irq)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference register state, updated from the bench's own writes.
    logic [31:0] m_func, m_gout, m_mask;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] dat,
                                          input logic [3:0] sel);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (sel[b]) r[8*b +: 8] = dat[8*b +: 8];
        return r;
    endfunction

    task automatic wb_access(input logic [31:0] adr, input logic we, input logic [31:0] dat,
                             input logic [3:0] sel, output logic [31:0] rdat);
        bit got;
        got = 0;
        @(posedge clk); #1;
        wb.wbs_adr_i = adr; wb.wbs_we_i = we; wb.wbs_dat_i = dat; wb.wbs_sel_i = sel;
        wb.wbs_cyc_i = 1'b1; wb.wbs_stb_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (wb.wbs_ack_o) begin got = 1; break; end
        end
        rdat = wb.wbs_dat_o;
        wb.wbs_cyc_i = 1'b0; wb.wbs_stb_i = 1'b0; wb.wbs_we_i = 1'b0;
        if (!got) begin
            n_checks++; n_fail++;
            $display("FAIL wb_timeout adr=%h actual ack=0 expected ack=1", adr);
        end
    endtask

    task automatic wr(input logic [5:0] off, input logic [31:0] dat, input logic [3:0] sel);
        logic [31:0] d;
        wb_access(BASE | {24'h0, off, 2'b00}, 1'b1, dat, sel, d);
        case (off)
            6'h00: m_func = merge(m_func, dat, sel) & V_FUNC;
            6'h01: m_gout = merge(m_gout, dat, sel) & V_PIN;
            6'h04: m_mask = merge(m_mask, dat, sel) & V_PEND;
            default: ;
        endcase
    endtask

    task automatic rd(input logic [5:0] off, output logic [31:0] d);
        wb_access(BASE | {24'h0, off, 2'b00}, 1'b0, 32'h0, 4'h0, d);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        logic [31:0] d, exp;
        #2;
        n_checks++;
        if (wb.wbs_ack_o !== 1'b0 || wb.wbs_dat_o !== 32'h0 || irq !== 3'b000 ||
            io_oeb !== {NP{1'b1}} || io_out !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs actual ack=%b dat=%h irq=%b oeb=%h out=%h expected 0/0/0/fff/000",
                     wb.wbs_ack_o, wb.wbs_dat_o, irq, io_oeb, io_out);
        end
        @(posedge clk); #1; rst_n = 1'b1;
        m_func = 0; m_gout = 0; m_mask = 0;
        for (int o = 0; o < 6; o++) begin
            rd(6'(o), d);
            exp = (o == 5) ? ID_EXP : 32'h0;
            n_checks++;
            if (d !== exp) begin
                n_fail++;
                $display("FAIL reset_read off=%0d actual=%h expected=%h", o, d, exp);
            end
        end
    endtask

    task automatic test_mux;
        logic [31:0] d;
        logic [NP-1:0] eo, eoe;
        wr(6'h00, 32'h1, 4'hF);
        wr(6'h01, 32'h1, 4'hF);
        n_checks++;
        if (io_oeb[0] !== 1'b0 || io_out[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL mux_gpio_out0 actual oeb=%b out=%b expected oeb=0 out=1", io_oeb[0], io_out[0]);
        end
        wr(6'h00, 32'h00AA_AA01, 4'hF);
        wr(6'h00, 32'hFFFF_FFFF, 4'b0001);
        rd(6'h00, d);
        n_checks++;
        if (d !== 32'h00AA_AAFF) begin
            n_fail++;
            $display("FAIL func_byte_lane actual=%h expected=%h", d, 32'h00AA_AAFF);
        end
        for (int it = 0; it < 16; it++) begin
            wr(6'h00, $urandom, 4'hF);
            wr(6'h01, $urandom, 4'(1 + $urandom_range(0, 14)));
            periph_out = NP'($urandom); periph_oeb = NP'($urandom);
            #1;
            for (int k = 0; k < NP; k++) begin
                case (m_func[2*k +: 2])
                    2'd1:    begin eo[k] = m_gout[k];     eoe[k] = 1'b0;          end
                    2'd2:    begin eo[k] = periph_out[k]; eoe[k] = periph_oeb[k]; end
                    default: begin eo[k] = 1'b0;          eoe[k] = 1'b1;          end
                endcase
            end
            n_checks++;
            if (io_out !== eo || io_oeb !== eoe) begin
                n_fail++;
                $display("FAIL mux_random it=%0d actual out=%h oeb=%h expected out=%h oeb=%h",
                         it, io_out, io_oeb, eo, eoe);
            end
        end
        rd(6'h01, d);
        n_checks++;
        if (d !== m_gout) begin
            n_fail++;
            $display("FAIL gpio_out_read actual=%h expected=%h", d, m_gout);
        end
    endtask

    task automatic test_gpio_edge;
        logic [31:0] d;
        wr(6'h04, 32'h1 << 19, 4'hF);
        @(posedge clk); #1; io_in[3] = 1'b1;
        cycles(1);
        n_checks++;
        if (periph_in[3] !== 1'b0) begin
            n_fail++; $display("FAIL sync_t1 actual=%b expected=0", periph_in[3]);
        end
        cycles(1);
        n_checks++;
        if (periph_in[3] !== 1'b1) begin
            n_fail++; $display("FAIL sync_t2 actual=%b expected=1", periph_in[3]);
        end
        cycles(1);
        n_checks++;
        if (irq[1] !== 1'b0) begin
            n_fail++; $display("FAIL irq1_t3 actual=%b expected=0", irq[1]);
        end
        cycles(1);
        n_checks++;
        if (irq !== 3'b010) begin
            n_fail++; $display("FAIL irq1_t4 actual=%b expected=010", irq);
        end
        rd(6'h03, d);
        n_checks++;
        if (d !== (32'h1 << 19)) begin
            n_fail++; $display("FAIL pend_edge actual=%h expected=%h", d, 32'h1 << 19);
        end
        rd(6'h02, d);
        n_checks++;
        if (d !== 32'h8) begin
            n_fail++; $display("FAIL gpio_in_read actual=%h expected=%h", d, 32'h8);
        end
        wr(6'h03, 32'h1 << 19, 4'hF);
        cycles(2);
        n_checks++;
        if (irq[1] !== 1'b0) begin
            n_fail++; $display("FAIL irq1_cleared actual=%b expected=0", irq[1]);
        end
        io_in = '0;
        cycles(4);
    endtask

    task automatic test_random_edges;
        logic [31:0] d, mask_r;
        logic [NP-1:0] r;
        mask_r = $urandom;
        wr(6'h04, mask_r, 4'hF);
        for (int it = 0; it < 8; it++) begin
            r = NP'($urandom);
            io_in = r; cycles(4);
            io_in = '0; cycles(4);
            n_checks++;
            if (irq[1] !== |(r & m_mask[16 +: NP])) begin
                n_fail++;
                $display("FAIL edge_irq it=%0d actual=%b expected=%b", it, irq[1], |(r & m_mask[16 +: NP]));
            end
            rd(6'h03, d);
            n_checks++;
            if (d !== {4'h0, r, 16'h0}) begin
                n_fail++;
                $display("FAIL edge_pend it=%0d actual=%h expected=%h", it, d, {4'h0, r, 16'h0});
            end
            wr(6'h03, 32'hFFFF_FFFF, 4'hF);
            rd(6'h03, d);
            n_checks++;
            if (d !== 32'h0) begin
                n_fail++; $display("FAIL edge_w1c it=%0d actual=%h expected=0", it, d);
            end
        end
    endtask

    task automatic test_src_level;
        logic [31:0] d;
        wr(6'h04, 32'h4, 4'hF);
        src_irq = 4'b0100; cycles(5);
        wr(6'h03, 32'h4, 4'hF);
        rd(6'h03, d);
        n_checks++;
        if (d !== 32'h4) begin
            n_fail++; $display("FAIL src_held_pend actual=%h expected=%h", d, 32'h4);
        end
        n_checks++;
        if (irq !== 3'b001) begin
            n_fail++; $display("FAIL src_irq0 actual=%b expected=001", irq);
        end
        src_irq = '0; cycles(5);
        wr(6'h03, 32'h4, 4'hF);
        cycles(2);
        rd(6'h03, d);
        n_checks++;
        if (d !== 32'h0 || irq[0] !== 1'b0) begin
            n_fail++; $display("FAIL src_cleared actual pend=%h irq0=%b expected pend=0 irq0=0", d, irq[0]);
        end
        // Unmasking an already pending source raises irq on the next clock.
        wr(6'h04, 32'h0, 4'hF);
        src_irq = 4'b0001; cycles(4); src_irq = '0; cycles(4);
        n_checks++;
        if (irq[0] !== 1'b0) begin
            n_fail++; $display("FAIL masked_src actual=%b expected=0", irq[0]);
        end
        wr(6'h04, 32'h1, 4'hF);
        cycles(1);
        n_checks++;
        if (irq[0] !== 1'b1) begin
            n_fail++; $display("FAIL unmask_pending actual=%b expected=1", irq[0]);
        end
        wr(6'h03, 32'h1, 4'hF);
    endtask

    task automatic test_window;
        logic [31:0] d;
        @(posedge clk); #1;
        wb.wbs_adr_i = 32'h3000_2000; wb.wbs_we_i = 1'b0; wb.wbs_cyc_i = 1'b1; wb.wbs_stb_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (wb.wbs_ack_o !== 1'b0 || wb.wbs_dat_o !== 32'h0) begin
                n_fail++;
                $display("FAIL out_of_window cyc=%0d actual ack=%b dat=%h expected ack=0 dat=0",
                         i, wb.wbs_ack_o, wb.wbs_dat_o);
            end
        end
        wb.wbs_cyc_i = 1'b0; wb.wbs_stb_i = 1'b0;
        wb_access(32'h3000_1040, 1'b1, 32'hFFFF_FFFF, 4'hF, d);
        wb_access(32'h3000_1040, 1'b0, 32'h0, 4'h0, d);
        n_checks++;
        if (d !== 32'h0) begin
            n_fail++; $display("FAIL unmapped_read actual=%h expected=0", d);
        end
        rd(6'h00, d);
        n_checks++;
        if (d !== m_func) begin
            n_fail++; $display("FAIL unmapped_write_side_effect actual=%h expected=%h", d, m_func);
        end
    endtask

    task automatic test_back_to_back;
        @(posedge clk); #1;
        wb.wbs_adr_i = BASE | 32'h14; wb.wbs_we_i = 1'b0; wb.wbs_cyc_i = 1'b1; wb.wbs_stb_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (wb.wbs_ack_o !== ((i % 2) == 0) ||
                (wb.wbs_ack_o === 1'b1 && wb.wbs_dat_o !== ID_EXP)) begin
                n_fail++;
                $display("FAIL back_to_back cyc=%0d actual ack=%b dat=%h expected ack=%b",
                         i, wb.wbs_ack_o, wb.wbs_dat_o, (i % 2) == 0);
            end
        end
        wb.wbs_cyc_i = 1'b0; wb.wbs_stb_i = 1'b0;
    endtask

    task automatic test_reset_mid;
        logic [31:0] d;
        @(posedge clk); #1;
        wb.wbs_adr_i = BASE | 32'h04; wb.wbs_we_i = 1'b1; wb.wbs_dat_i = 32'hABC; wb.wbs_sel_i = 4'hF;
        wb.wbs_cyc_i = 1'b1; wb.wbs_stb_i = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (wb.wbs_ack_o !== 1'b1) begin
            n_fail++; $display("FAIL mid_ack_before actual=%b expected=1", wb.wbs_ack_o);
        end
        rst_n = 1'b0; #1;
        n_checks++;
        if (wb.wbs_ack_o !== 1'b0 || io_oeb !== {NP{1'b1}}) begin
            n_fail++;
            $display("FAIL mid_reset actual ack=%b oeb=%h expected ack=0 oeb=fff", wb.wbs_ack_o, io_oeb);
        end
        wb.wbs_cyc_i = 1'b0; wb.wbs_stb_i = 1'b0; wb.wbs_we_i = 1'b0;
        @(posedge clk); #1; rst_n = 1'b1;
        m_func = 0; m_gout = 0; m_mask = 0;
        rd(6'h01, d);
        n_checks++;
        if (d !== 32'h0) begin
            n_fail++; $display("FAIL mid_reset_reg actual=%h expected=0", d);
        end
    endtask

    initial begin
        wb.wbs_stb_i = 1'b0; wb.wbs_cyc_i = 1'b0; wb.wbs_we_i = 1'b0;
        wb.wbs_sel_i = 4'h0; wb.wbs_dat_i = 32'h0; wb.wbs_adr_i = 32'h0;
        m_func = 0; m_gout = 0; m_mask = 0;
        test_reset;
        test_mux;
        test_gpio_edge;
        test_random_edges;
        test_src_level;
        test_window;
        test_back_to_back;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
